// File: rtl/fb_pixel_loader.sv
// fb_pixel_loader: packs a byte stream (two bytes per pixel) into 12-bit
// pixels and writes them in raster order into the frame block RAM.
// Pixel layout on din: {R[3:0], B[3:0], G[3:0]}.
// Optional feature macro: FB_LOADER_CHECKSUM_EN enables a 16-bit running
// pixel sum on the checksum output. Without it, checksum is tied to zero.
module fb_pixel_loader #(
    parameter int H_RES = 320,
    parameter int V_RES = 240,
    parameter int AW    = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic [11:0]   din,
    output logic          busy,
    output logic          frame_done,
    output logic [7:0]    row,
    output logic [15:0]   checksum
);

    localparam int            CW        = $clog2(H_RES);
    localparam logic [AW-1:0] LAST_ADDR = AW'(H_RES * V_RES - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(H_RES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        r_state;
    logic [7:0]    r_hi;
    logic [CW-1:0] r_col;
    logic [7:0]    r_row;
    logic [AW-1:0] r_addr;
    logic [11:0]   r_din;
    logic          r_we;
    logic          r_busy;
    logic          r_frame_done;

    logic          w_hs;
    logic          w_last_pix;
    logic          w_last_col;
    logic          w_start_ok;
    logic [AW-1:0] w_addr_nxt;

    // Handshake, boundary decodes and the explicitly wrapping next address.
    always_comb begin
        w_hs       = s_valid & s_ready;
        w_last_pix = (r_addr == LAST_ADDR);
        w_last_col = (r_col == LAST_COL);
        w_start_ok = (r_state == S_IDLE) && start && !abort;
        if (w_last_pix) begin
            w_addr_nxt = {AW{1'b0}};
        end else begin
            w_addr_nxt = r_addr + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    // Main loader FSM with registered RAM-port and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_hi         <= 8'h00;
            r_col        <= {CW{1'b0}};
            r_row        <= 8'h00;
            r_addr       <= {AW{1'b0}};
            r_din        <= 12'h000;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state <= S_HI;
                        r_busy  <= 1'b1;
                        r_addr  <= {AW{1'b0}};
                        r_col   <= {CW{1'b0}};
                        r_row   <= 8'h00;
                    end
                end
                S_HI: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_hs) begin
                        r_hi    <= s_data;
                        r_state <= S_LO;
                    end
                end
                S_LO: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_hs) begin
                        // Upper nibble of the second byte carries no data.
                        r_din   <= {r_hi, s_data[3:0]};
                        r_we    <= 1'b1;
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    // The write happens this cycle regardless of abort.
                    if (w_last_col) begin
                        r_col <= {CW{1'b0}};
                    end else begin
                        r_col <= r_col + {{(CW-1){1'b0}}, 1'b1};
                    end
                    // On the final pixel, addr and row hold their last values.
                    if (!w_last_pix) begin
                        r_addr <= w_addr_nxt;
                        if (w_last_col) begin
                            r_row <= r_row + 8'd1;
                        end
                    end
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_last_pix) begin
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_state <= S_HI;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FB_LOADER_CHECKSUM_EN
    logic [15:0] r_checksum;

    // Running mod-2^16 sum of written pixels; clears on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= 16'h0000;
        end else if (w_start_ok) begin
            r_checksum <= 16'h0000;
        end else if (r_state == S_WR) begin
            r_checksum <= r_checksum + {4'h0, r_din};
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 16'h0000;
`endif

    assign s_ready    = (r_state == S_HI) || (r_state == S_LO);
    assign we         = r_we;
    assign addr       = r_addr;
    assign din        = r_din;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign row        = r_row;

endmodule

// File: tb/tb_fb_pixel_loader.sv
// Self-checking bench for fb_pixel_loader. A reduced frame height keeps the
// full-frame run short while H_RES stays 320 so row wrapping is exercised.
module tb_fb_pixel_loader;

    localparam int H_RES = 320;
    localparam int V_RES = 8;
    localparam int AW    = 17;
    localparam int NPIX  = H_RES * V_RES;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          we;
    logic [AW-1:0] addr;
    logic [11:0]   din;
    logic          busy;
    logic          frame_done;
    logic [7:0]    row;
    logic [15:0]   checksum;

    int checks   = 0;
    int errors   = 0;
    int we_count = 0;
    int fd_count = 0;

    logic [AW+11:0] sb_q[$];
    logic [AW+11:0] m_exp;
    logic [AW-1:0]  exp_addr;
    logic [15:0]    exp_sum;

    fb_pixel_loader #(.H_RES(H_RES), .V_RES(V_RES), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .we(we), .addr(addr), .din(din), .busy(busy),
        .frame_done(frame_done), .row(row), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Expected checksum depends on whether the optional accumulator is built.
    function automatic logic [15:0] exp_ck(input logic [15:0] s);
`ifdef FB_LOADER_CHECKSUM_EN
        return s;
`else
        return 16'h0000;
`endif
    endfunction

    // Scoreboard monitor: every write must match the oldest expected pixel.
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
        if (we === 1'b1) begin
            we_count++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_we: addr=%0d din=%h, required no write", addr, din);
            end else begin
                m_exp = sb_q.pop_front();
                if ({addr, din} !== m_exp) begin
                    errors++;
                    $display("FAIL sb_write: addr=%0d din=%h, required addr=%0d din=%h",
                             addr, din, m_exp[AW+11:12], m_exp[11:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok      = 1'b0;
        s_data  = b;
        s_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: s_ready=%b, required 1 within 100 cycles", s_ready);
        end
        s_valid = 1'b0;
    endtask

    task automatic send_pixel(input logic [11:0] pix, input logic [3:0] junk);
        sb_q.push_back({exp_addr, pix});
        send_byte(pix[11:4]);
        send_byte({junk, pix[3:0]});
        exp_addr = exp_addr + 1'b1;
        exp_sum  = exp_sum + {4'h0, pix};
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        exp_addr = '0;
        exp_sum  = 16'h0000;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s_ready, we, addr, din, busy, frame_done, row, checksum} !== '0) begin
            errors++;
            $display("FAIL por_values: s_ready=%b we=%b addr=%0d din=%h busy=%b fd=%b row=%0d ck=%h, required all zero",
                     s_ready, we, addr, din, busy, frame_done, row, checksum);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_start();
        for (int n = 0; n < 5; n++) send_pixel(12'(n * 7 + 1), 4'h5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({s_ready, we, addr, din, busy, frame_done, row, checksum} !== '0) begin
            errors++;
            $display("FAIL midload_reset: s_ready=%b we=%b addr=%0d din=%h busy=%b fd=%b row=%0d ck=%h, required all zero",
                     s_ready, we, addr, din, busy, frame_done, row, checksum);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: s_ready=%b busy=%b, required 0 0", s_ready, busy);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL reset_pending: %0d writes outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_single_pixel();
        do_start();
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: busy=%b s_ready=%b, required 1 1", busy, s_ready);
        end
        send_pixel(12'hA5C, 4'h3);
        checks++;
        if (we !== 1'b1 || addr !== 17'd0 || din !== 12'hA5C) begin
            errors++;
            $display("FAIL single_write: we=%b addr=%0d din=%h, required 1 0 a5c", we, addr, din);
        end
        @(posedge clk);
        #1;
        checks++;
        if (we !== 1'b0 || addr !== 17'd1 || row !== 8'd0 || checksum !== exp_ck(16'h0A5C)) begin
            errors++;
            $display("FAIL single_after: we=%b addr=%0d row=%0d ck=%h, required 0 1 0 %h",
                     we, addr, row, checksum, exp_ck(16'h0A5C));
        end
        do_abort();
    endtask

    task automatic test_backpressure();
        int wc;
        do_start();
        sb_q.push_back({exp_addr, 12'h7E9});
        send_byte(8'h7E);
        wc = we_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (we !== 1'b0 || s_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d we=%b s_ready=%b, required 0 1", i, we, s_ready);
            end
        end
        @(posedge clk);
        #1;
        send_byte(8'hC9);
        exp_addr = exp_addr + 1'b1;
        checks++;
        if (we !== 1'b1 || din !== 12'h7E9 || we_count != wc) begin
            errors++;
            $display("FAIL bp_resume: we=%b din=%h writes_in_gap=%0d, required 1 7e9 0",
                     we, din, we_count - wc);
        end
        do_abort();
    endtask

    task automatic test_abort();
        do_start();
        we_count = 0;
        fd_count = 0;
        for (int n = 0; n < 100; n++) send_pixel(12'(n * 37 + 11), 4'hA);
        do_abort();
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b s_ready=%b, required 0 0", busy, s_ready);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (we_count != 100 || fd_count != 0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL abort_counts: writes=%0d frame_done=%0d pending=%0d, required 100 0 0",
                     we_count, fd_count, sb_q.size());
        end
        checks++;
        if (checksum !== exp_ck(exp_sum)) begin
            errors++;
            $display("FAIL abort_cksum_hold: checksum=%h, required %h", checksum, exp_ck(exp_sum));
        end
        do_start();
        checks++;
        if (addr !== 17'd0 || checksum !== 16'h0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart: addr=%0d checksum=%h busy=%b, required 0 0000 1", addr, checksum, busy);
        end
        send_pixel(12'h123, 4'h0);
        do_abort();
    endtask

    task automatic test_row_boundary();
        do_start();
        for (int n = 0; n < H_RES; n++) begin
            send_pixel(12'(n), 4'h6);
            if (n == 10) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                checks++;
                if (addr !== exp_addr || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ignored_start: addr=%0d busy=%b, required %0d 1", addr, busy, exp_addr);
                end
            end
        end
        checks++;
        if (row !== 8'd0 || addr !== 17'(H_RES - 1)) begin
            errors++;
            $display("FAIL row_before_wrap: row=%0d addr=%0d, required 0 %0d", row, addr, H_RES - 1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (row !== 8'd1 || addr !== 17'(H_RES)) begin
            errors++;
            $display("FAIL row_wrap: row=%0d addr=%0d, required 1 %0d", row, addr, H_RES);
        end
        send_pixel(12'hFFF, 4'h1);
        do_abort();
    endtask

    task automatic test_full_frame();
        do_start();
        we_count = 0;
        fd_count = 0;
        for (int n = 0; n < NPIX; n++) send_pixel(12'(n % 4096), 4'(n));
        checks++;
        if (we !== 1'b1 || addr !== 17'(NPIX - 1)) begin
            errors++;
            $display("FAIL last_write: we=%b addr=%0d, required 1 %0d", we, addr, NPIX - 1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: frame_done=%b busy=%b, required 1 1", frame_done, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || row !== 8'(V_RES - 1) || addr !== 17'(NPIX - 1)) begin
            errors++;
            $display("FAIL after_done: fd=%b busy=%b row=%0d addr=%0d, required 0 0 %0d %0d",
                     frame_done, busy, row, addr, V_RES - 1, NPIX - 1);
        end
        checks++;
        if (checksum !== exp_ck(exp_sum)) begin
            errors++;
            $display("FAIL frame_cksum: checksum=%h, required %h", checksum, exp_ck(exp_sum));
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (we_count != NPIX || fd_count != 1 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL frame_counts: writes=%0d frame_done=%0d pending=%0d, required %0d 1 0",
                     we_count, fd_count, sb_q.size(), NPIX);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        s_data   = 8'h00;
        s_valid  = 1'b0;
        exp_addr = '0;
        exp_sum  = 16'h0000;
        test_reset();
        test_single_pixel();
        test_backpressure();
        test_abort();
        test_row_boundary();
        test_full_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_pixel_loader.md
# fb_pixel_loader

Frame-buffer writer for the 320×240, 12-bit digital photo frame buffer. It accepts a byte stream over a valid/ready handshake and packs each pair of bytes into one 12-bit pixel. Pixels are written in raster order through the write port of the 76800-entry frame block RAM. The VGA display path reads the same memory, so this block lets new photos be loaded without re-synthesis.

## Interface
Parameters:
- H_RES, 320, pixels per row
- V_RES, 240, rows per frame
- AW, 17, address width (must satisfy 2^AW ≥ H_RES·V_RES)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a frame load at address 0
- abort  in  1  level; terminates an in-progress load
- s_data  in  8  stream byte
- s_valid  in  1  s_data valid
- s_ready  out  1  loader can accept a byte
- we  out  1  RAM write enable, one-cycle pulse per pixel
- addr  out  AW  RAM write address
- din  out  12  RAM write data, packed {R[3:0],B[3:0],G[3:0]}
- busy  out  1  high from the cycle after start is accepted until return to IDLE
- frame_done  out  1  one-cycle pulse when the last pixel has been written
- row  out  8  current row being written (0..V_RES-1)
- checksum  out  16  running pixel sum; see Configuration

## Operation
- FSM states: IDLE, HI, LO, WR, DONE.
- IDLE:
  - s_ready=0.
  - start=1 and abort=0 → HI; clear addr, column counter, row and checksum.
- HI:
  - s_ready=1.
  - On a handshake (s_valid & s_ready), latch s_data as pixel[11:4] (R,B), then → LO.
- LO:
  - s_ready=1.
  - On a handshake, latch s_data[3:0] as pixel[3:0] (G); s_data[7:4] is ignored. Then → WR.
- WR:
  - we=1, din=packed pixel, addr=current address.
  - Next cycle: addr+1; column+1.
  - When column reaches H_RES-1, column wraps to 0 and row increments.
  - If addr was H_RES·V_RES-1 → DONE; otherwise → HI.
- DONE: frame_done=1 for this single cycle, then → IDLE. addr holds the last value and row holds V_RES-1 until the next start.
- abort=1 in HI, LO or WR → IDLE next cycle. No further we, no frame_done. A WR coinciding with abort still performs its write.
- start while busy is ignored. Simultaneous start and abort in IDLE: abort wins and the FSM stays in IDLE.
- Stalls: s_valid low in HI or LO holds the state indefinitely; there is no timeout.
- Arithmetic: addr wraps explicitly to 0 after H_RES·V_RES-1 (never free-runs past 76799). checksum is mod 2^16.

## Timing
- Reset values: s_ready=0, we=0, addr=0, din=0, busy=0, frame_done=0, row=0, checksum=0; state IDLE.
- Outputs are registered, except s_ready, which is decoded from state (HI/LO).
- Latency from LO handshake to we is 1 cycle.
- Peak throughput is 1 pixel per 3 cycles with s_valid held high. A full frame takes 230400 cycles plus 2 (start→HI, DONE).
- busy rises the cycle after start and falls the cycle after frame_done.
- Reset mid-frame returns to IDLE immediately. Partially written RAM contents are left as is.

## Configuration
- FB_LOADER_CHECKSUM_EN defined:
  - checksum accumulates the zero-extended 12-bit pixel on every WR cycle.
  - It clears on an accepted start and holds after DONE or abort.
- Not defined: checksum is tied to 16'h0000 and the accumulator logic is absent.

## Test plan
- Reset: assert rst mid-load after 5 pixels → all outputs at reset values, state IDLE, s_ready=0 on the following cycle.
- Single pixel: start, then bytes 0xA5, 0x3C → we pulse with addr=0, din=12'hA5C; next addr=1, row=0.
- Full frame: stream 153600 bytes, with pixel n encoded as n mod 4096 → exactly 76800 we pulses. Last write is at addr=76799. One frame_done, busy falls, row=239. checksum (with macro) equals Σ(n mod 4096) mod 65536.
- Backpressure: drop s_valid for 10 cycles between the HI and LO bytes → no we during the gap, state held, and the correct pixel is written after resume.
- Abort: raise abort after 100 pixels → IDLE next cycle, no frame_done. A following start restarts at addr=0, and checksum clears.
- Row boundary and ignored start: after 320 pixels row=1 and column=0. A start pulse mid-frame produces no address reset.
